// File: rtl/message_loader.sv
// ============================================================================
// Module   : message_loader
// Purpose  : Buffers an ASCII byte stream as 7-bit display words and, on
//            commit, streams exactly WORD_COUNT words to the column display.
//            Define RAW_COLUMN_EN to pass bytes 0x80-0xBF through as raw columns.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module message_loader #(
    parameter int WORD_COUNT = 20,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             commit,
    output logic [6:0]       dout,
    output logic             busy,
    output logic [CNT_W-1:0] fill
);

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(WORD_COUNT);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(WORD_COUNT - 1);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam logic [6:0]       c_PLAY  = 7'h7F;
    localparam logic [6:0]       c_BLANK = 7'h40;

    state_t           r_state;
    logic [6:0]       r_dout;
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] r_rd;
    logic [CNT_W-1:0] r_wr;
    logic [CNT_W-1:0] r_emit;
    logic [6:0]       r_mem [WORD_COUNT];

    logic [6:0] w_map;
    logic       w_accept;
    logic       w_start;
    logic       w_bypass;
    logic       w_emit;
    logic       w_push;
    logic       w_pop;

    function automatic logic [CNT_W-1:0] f_next(input logic [CNT_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_ONE;
    endfunction

    always_comb begin
        w_map = c_BLANK;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            w_map = {1'b1, in_data[5:0] - 6'h28};
        end else if (in_data >= 8'h41 && in_data <= 8'h5A) begin
            w_map = {1'b1, in_data[5:0] - 6'h20};
        end else if (in_data >= 8'h61 && in_data <= 8'h7A) begin
            // Lowercase low six bits already equal the uppercase code.
            w_map = {1'b1, in_data[5:0]};
        end
`ifdef RAW_COLUMN_EN
        else if (in_data >= 8'h80 && in_data <= 8'hBF) begin
            w_map = {1'b0, in_data[5:0]};
        end
`endif
    end

    assign in_ready = (r_state == ST_PLAY) && (r_fill < c_DEPTH);
    assign busy     = (r_state == ST_LOAD);
    assign fill     = r_fill;
    assign dout     = r_dout;

    assign w_accept = in_valid && in_ready;
    assign w_start  = (r_state == ST_PLAY) && commit;
    // An empty FIFO plus a byte on the commit edge: that byte is emitted directly.
    assign w_bypass = w_start && w_accept && (r_fill == '0);
    assign w_emit   = w_start || ((r_state == ST_LOAD) && (r_emit != c_DEPTH));
    assign w_pop    = w_emit && (r_fill != '0);
    assign w_push   = w_accept && !w_bypass;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_map;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PLAY;
            r_dout  <= c_PLAY;
            r_fill  <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_emit  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= f_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_next(r_rd);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + c_ONE;
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - c_ONE;
            end

            case (r_state)
                ST_PLAY: begin
                    if (commit) begin
                        r_state <= ST_LOAD;
                        r_emit  <= c_ONE;
                        r_dout  <= w_pop ? r_mem[r_rd] : (w_bypass ? w_map : c_BLANK);
                    end
                end
                ST_LOAD: begin
                    if (r_emit == c_DEPTH) begin
                        r_state <= ST_PLAY;
                        r_emit  <= '0;
                        r_dout  <= c_PLAY;
                    end else begin
                        r_emit  <= r_emit + c_ONE;
                        r_dout  <= w_pop ? r_mem[r_rd] : c_BLANK;
                    end
                end
                default: begin
                    r_state <= ST_PLAY;
                    r_dout  <= c_PLAY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_message_loader.sv
// ============================================================================
// Module   : tb_message_loader
// Purpose  : Self-checking bench for message_loader with directed scenarios
//            and randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_message_loader;

    localparam int WC = 20;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          commit;
    logic [6:0]    dout;
    logic          busy;
    logic [CW-1:0] fill;

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] q[$];
    bit         m_load;
    int         m_rem;
    logic [6:0] m_dout;

    message_loader #(.WORD_COUNT(WC), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .commit   (commit),
        .dout     (dout),
        .busy     (busy),
        .fill     (fill)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_map(input logic [7:0] b_in);
        logic [7:0] b;
        b = b_in;
        if (b >= "0" && b <= "9") return 7'h48 + 7'(b - "0");
        if (b >= "a" && b <= "z") b = b - 8'd32;
        if (b >= "A" && b <= "Z") return 7'h61 + 7'(b - "A");
`ifdef RAW_COLUMN_EN
        if (b >= 8'h80 && b <= 8'hBF) return 7'(b - 8'h80);
`endif
        return 7'h40;
    endfunction

    function automatic logic [6:0] model_emit();
        if (q.size() > 0) return q.pop_front();
        return 7'h40;
    endfunction

    // One clock: drive inputs, advance the model on the edge, settle 1 time unit.
    task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit c);
        bit rdy;
        rst = r; in_valid = v; in_data = d; commit = c;
        rdy = !m_load && (q.size() < WC);
        @(posedge clk);
        if (r) begin
            q.delete(); m_load = 0; m_rem = 0; m_dout = 7'h7F;
        end else if (m_load) begin
            if (m_rem > 0) begin
                m_dout = model_emit(); m_rem--;
            end else begin
                m_load = 0; m_dout = 7'h7F;
            end
        end else begin
            if (v && rdy) q.push_back(ref_map(d));
            if (c) begin
                m_load = 1; m_rem = WC - 1; m_dout = model_emit();
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        cycle(0, 0, 8'h00, 0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({dout, in_ready, busy, fill} !== {7'h7F, 1'b1, 1'b0, 5'd0})
                $display("FAIL reset_idle[%0d]: dout/rdy/busy/fill got %h/%b/%b/%0d want 7f/1/0/0",
                         i, dout, in_ready, busy, fill);
            else n_pass++;
            cycle(0, 0, 8'h00, 0);
        end
    endtask

    task automatic test_hi();
        logic [6:0] exp_w;
        do_reset();
        cycle(0, 1, "H", 0);
        cycle(0, 1, "I", 0);
        cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < WC; i++) begin
            exp_w = (i == 0) ? 7'h68 : (i == 1) ? 7'h69 : 7'h40;
            n_total++;
            if (dout !== exp_w || busy !== 1'b1)
                $display("FAIL hi_word[%0d]: dout/busy got %h/%b want %h/1", i, dout, busy, exp_w);
            else n_pass++;
            cycle(0, 0, 8'h00, 0);
        end
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (dout !== 7'h7F || busy !== 1'b0)
                $display("FAIL hi_hold[%0d]: dout/busy got %h/%b want 7f/0", i, dout, busy);
            else n_pass++;
            cycle(0, 0, 8'h00, 0);
        end
    endtask

    task automatic test_lowercase();
        logic [7:0] msg [4];
        logic [6:0] expw [4];
        msg  = '{"a", "0", " ", "z"};
        expw = '{7'h61, 7'h48, 7'h40, 7'h7A};
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, msg[i], 0);
        n_total++;
        if (fill !== 5'd4) $display("FAIL lower_fill: got %0d want 4", fill);
        else n_pass++;
        cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < WC; i++) begin
            n_total++;
            if (dout !== ((i < 4) ? expw[i] : 7'h40))
                $display("FAIL lower_word[%0d]: got %h want %h", i, dout, (i < 4) ? expw[i] : 7'h40);
            else n_pass++;
            cycle(0, 0, 8'h00, 0);
        end
        n_total++;
        if (dout !== 7'h7F) $display("FAIL lower_end: got %h want 7f", dout);
        else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < WC; i++) cycle(0, 1, 8'("A" + i), 0);
        n_total++;
        if (fill !== 5'd20 || in_ready !== 1'b0)
            $display("FAIL full_level: fill/rdy got %0d/%b want 20/0", fill, in_ready);
        else n_pass++;
        cycle(0, 1, "U", 0);
        n_total++;
        if (fill !== 5'd20) $display("FAIL full_hold: fill got %0d want 20", fill);
        else n_pass++;
        cycle(0, 1, "U", 1);
        for (int i = 0; i < WC; i++) begin
            n_total++;
            if (dout !== 7'(7'h61 + i) || in_ready !== 1'b0)
                $display("FAIL full_word[%0d]: dout/rdy got %h/%b want %h/0", i, dout, in_ready, 7'(7'h61 + i));
            else n_pass++;
            cycle(0, 1, "U", 0);
        end
        n_total++;
        if (dout !== 7'h7F || fill !== 5'd0 || in_ready !== 1'b1)
            $display("FAIL full_after: dout/fill/rdy got %h/%0d/%b want 7f/0/1", dout, fill, in_ready);
        else n_pass++;
        cycle(0, 1, "U", 0);
        n_total++;
        if (fill !== 5'd1) $display("FAIL full_late_byte: fill got %0d want 1", fill);
        else n_pass++;
    endtask

    task automatic test_commit_same_edge();
        do_reset();
        cycle(0, 1, "B", 1);
        n_total++;
        if (dout !== 7'h62 || fill !== 5'd0 || busy !== 1'b1)
            $display("FAIL same_edge: dout/fill/busy got %h/%0d/%b want 62/0/1", dout, fill, busy);
        else n_pass++;
        for (int i = 1; i < WC; i++) cycle(0, 1, "C", 1);
        n_total++;
        if (dout !== 7'h40 || busy !== 1'b1) $display("FAIL same_edge_tail: got %h/%b want 40/1", dout, busy);
        else n_pass++;
        cycle(0, 0, 8'h00, 0);
        n_total++;
        if (dout !== 7'h7F || fill !== 5'd0)
            $display("FAIL same_edge_end: dout/fill got %h/%0d want 7f/0", dout, fill);
        else n_pass++;
    endtask

    task automatic test_raw_and_midreset();
        logic [6:0] exp_raw;
`ifdef RAW_COLUMN_EN
        exp_raw = 7'h15;
`else
        exp_raw = 7'h40;
`endif
        do_reset();
        cycle(0, 1, 8'h95, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, 8'("0" + i), 0);
        cycle(0, 0, 8'h00, 1);
        n_total++;
        if (dout !== exp_raw) $display("FAIL raw_word: got %h want %h", dout, exp_raw);
        else n_pass++;
        for (int i = 1; i <= 7; i++) cycle(0, 0, 8'h00, 0);
        n_total++;
        if (dout !== 7'h4E) $display("FAIL mid_word7: got %h want 4e", dout);
        else n_pass++;
        cycle(1, 0, 8'h00, 0);
        n_total++;
        if ({dout, fill, busy, in_ready} !== {7'h7F, 5'd0, 1'b0, 1'b1})
            $display("FAIL mid_reset: dout/fill/busy/rdy got %h/%0d/%b/%b want 7f/0/0/1",
                     dout, fill, busy, in_ready);
        else n_pass++;
        cycle(0, 0, 8'h00, 0);
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit v, c, r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 3))
                0: d = 8'($urandom_range(0, 255));
                1: d = 8'("a" + $urandom_range(0, 25));
                2: d = 8'("0" + $urandom_range(0, 9));
                default: d = 8'($urandom_range(8'h80, 8'hBF));
            endcase
            cycle(r, v, d, c);
            n_total++;
            if ({dout, busy, in_ready, fill} !== {m_dout, m_load, !m_load && (q.size() < WC), CW'(q.size())})
                $display("FAIL random[%0d]: dout/busy/rdy/fill got %h/%b/%b/%0d want %h/%b/%b/%0d",
                         i, dout, busy, in_ready, fill, m_dout, m_load,
                         !m_load && (q.size() < WC), q.size());
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; commit = 1'b0;
        m_load = 0; m_rem = 0; m_dout = 7'h7F;
        test_reset();
        test_hi();
        test_lowercase();
        test_full();
        test_commit_same_edge();
        test_raw_and_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
